// File: rtl/alu_mult_sequencer_if.sv
// Bundle between the multiply sequencer, its requester and the shared ALU.
// The sequencer uses the slave view; the requester/ALU side uses the master view.
interface alu_mult_sequencer_if #(
    parameter int N = 64
);
    logic         start;
    logic [N-1:0] multiplicand;
    logic [N-1:0] multiplier;
    logic         busy;
    logic         done;
    logic [N-1:0] product;
    logic         ovf;
    logic [N-1:0] alu_A;
    logic [N-1:0] alu_B;
    logic [4:0]   alu_FS;
    logic         alu_C0;
    logic [N-1:0] alu_F;
    logic [3:0]   alu_status;

    modport slave (
        input  start, multiplicand, multiplier, alu_F, alu_status,
        output busy, done, product, ovf, alu_A, alu_B, alu_FS, alu_C0
    );

    modport master (
        output start, multiplicand, multiplier, alu_F, alu_status,
        input  busy, done, product, ovf, alu_A, alu_B, alu_FS, alu_C0
    );
endinterface

// File: rtl/alu_mult_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the shared LEGv8 ALU.
// One ADD cycle per set multiplier bit, one SHIFT cycle per bit position up to
// the highest set bit. Low N bits of the product plus a sticky overflow flag.
module alu_mult_sequencer #(
    parameter int         N      = 64,
    parameter logic [4:0] FS_ADD = 5'b01000,
    parameter logic [4:0] FS_SHL = 5'b10000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    alu_mult_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    state_t       state;
    logic [N-1:0] acc;
    logic [N-1:0] mcand;
    logic [N-1:0] mplr;
    logic         ovf_acc;
    logic         busy_q;
    logic         done_q;
    logic [N-1:0] product_q;
    logic         ovf_q;

    logic [N-1:0] mplr_sh;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [4:0]   alu_fs;

    // Only the carry bit of the ALU status matters for unsigned overflow.
    logic         unused_status;
    assign unused_status = ^{bus.alu_status[3], bus.alu_status[1:0]};

    assign mplr_sh = mplr >> 1;

    // ALU operand/function mux; the ALU is left at zero unless we own it.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_fs = '0;
        case (state)
            ADD: begin
                alu_a  = acc;
                alu_b  = mcand;
                alu_fs = FS_ADD;
            end
            SHIFT: begin
                alu_a  = mcand;
                alu_b  = {{(N-1){1'b0}}, 1'b1};
                alu_fs = FS_SHL;
            end
            default: ;
        endcase
    end

    // Controller FSM with registered status/result outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplr      <= '0;
            ovf_acc   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a new request exactly like IDLE so ops can chain.
                IDLE, DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start) begin
                        acc     <= '0;
                        mcand   <= bus.multiplicand;
                        mplr    <= bus.multiplier;
                        ovf_acc <= 1'b0;
                        if (bus.multiplier == '0) begin
                            state     <= DONE;
                            done_q    <= 1'b1;
                            product_q <= '0;
                            ovf_q     <= 1'b0;
                        end else begin
                            busy_q <= 1'b1;
                            state  <= bus.multiplier[0] ? ADD : SHIFT;
                        end
                    end
                end
                ADD: begin
                    acc     <= bus.alu_F;
                    ovf_acc <= ovf_acc | bus.alu_status[2];
                    state   <= SHIFT;
                end
                SHIFT: begin
                    mcand   <= bus.alu_F;
                    mplr    <= mplr_sh;
                    // A set MSB falling off while multiplier bits remain means
                    // a later partial product would exceed N bits.
                    ovf_acc <= ovf_acc | (mcand[N-1] & (mplr_sh != '0));
                    if (mplr_sh == '0) begin
                        state     <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        product_q <= acc;
                        ovf_q     <= ovf_acc;
                    end else begin
                        state <= mplr[1] ? ADD : SHIFT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
    assign bus.ovf     = ovf_q;
    assign bus.alu_A   = alu_a;
    assign bus.alu_B   = alu_b;
    assign bus.alu_FS  = alu_fs;
    assign bus.alu_C0  = 1'b0;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed bench for alu_mult_sequencer with a behavioural LEGv8 ALU model.
module tb_alu_mult_sequencer;

    localparam int         N      = 64;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SHL = 5'b10000;

    logic clock;
    logic reset_n;

    alu_mult_sequencer_if #(.N(N)) bus ();

    alu_mult_sequencer #(.N(N), .FS_ADD(FS_ADD), .FS_SHL(FS_SHL)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ALU model: ADD with carry out, shift left by B[5:0].
    logic [N:0]   alu_sum;
    logic [N-1:0] alu_f;
    logic [3:0]   alu_st;
    always_comb begin
        alu_sum = {1'b0, bus.alu_A} + {1'b0, bus.alu_B} + {{N{1'b0}}, bus.alu_C0};
        alu_f   = '0;
        alu_st  = '0;
        case (bus.alu_FS)
            FS_ADD: begin
                alu_f     = alu_sum[N-1:0];
                alu_st[2] = alu_sum[N];
            end
            FS_SHL:  alu_f = bus.alu_A << bus.alu_B[5:0];
            default: alu_f = '0;
        endcase
        alu_st[1] = alu_f[N-1];
        alu_st[0] = (alu_f == '0);
    end
    assign bus.alu_F      = alu_f;
    assign bus.alu_status = alu_st;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Runs from the current negedge until done (bounded), logging ALU usage.
    task automatic wait_done(input int start_cyc, output int cyc, output int nadd,
                             output int nshl, output logic [127:0] seq, output int bad);
        cyc  = start_cyc;
        nadd = 0;
        nshl = 0;
        seq  = '0;
        bad  = 0;
        while (bus.done !== 1'b1 && cyc < 300) begin
            if (bus.busy !== 1'b1) bad++;
            if (bus.alu_FS == FS_ADD) begin
                nadd++;
                seq = {seq[126:0], 1'b1};
            end else if (bus.alu_FS == FS_SHL) begin
                nshl++;
                seq = {seq[126:0], 1'b0};
                if (bus.alu_B !== 64'd1) bad++;
            end else begin
                bad++;
            end
            if (bus.alu_C0 !== 1'b0) bad++;
            @(negedge clock);
            cyc++;
        end
    endtask

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] prod;
        logic        ovf;
        int          lat;
        int          p;
        int          l;
    } vec_t;

    vec_t vecs [11];

    int           cyc, nadd, nshl, bad, hits;
    logic [127:0] seq;
    string        tag;

    initial begin
        //             multiplicand            multiplier              product                 ovf  lat  P   L
        vecs[0]  = '{64'd3,                  64'd5,                  64'd15,                 1'b0,  6,  2,  3};
        vecs[1]  = '{64'h1234,               64'd0,                  64'd0,                  1'b0,  1,  0,  0};
        vecs[2]  = '{64'h8000_0000_0000_0000, 64'd2,                 64'd0,                  1'b1,  4,  1,  2};
        vecs[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3,  1,  1};
        vecs[4]  = '{64'd7,                  64'd7,                  64'd49,                 1'b0,  7,  3,  3};
        vecs[5]  = '{64'd0,                  64'hFF,                 64'd0,                  1'b0, 17,  8,  8};
        vecs[6]  = '{64'h1_0000_0000,        64'h1_0000_0000,        64'd0,                  1'b1, 35,  1, 33};
        vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                1'b1, 129, 64, 64};
        vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd3,                 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 5,  2,  2};
        vecs[9]  = '{64'h6000_0000_0000_0000, 64'd3,                 64'h2000_0000_0000_0000, 1'b1, 5,  2,  2};
        vecs[10] = '{64'hDEAD,               64'h10,                 64'hDEAD0,              1'b0,  7,  1,  5};

        reset_n          = 1'b0;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_product", bus.product, 64'd0);
        chk("rst_ovf", {63'd0, bus.ovf}, 64'd0);
        chk("rst_fs", {59'd0, bus.alu_FS}, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Table of single operations, each followed by a return to IDLE.
        for (int i = 0; i < 11; i++) begin
            tag = $sformatf("v%0d", i);
            bus.start        = 1'b1;
            bus.multiplicand = vecs[i].a;
            bus.multiplier   = vecs[i].b;
            @(negedge clock);
            bus.start = 1'b0;
            wait_done(1, cyc, nadd, nshl, seq, bad);
            chk({tag, "_done"}, {63'd0, bus.done}, 64'd1);
            chk({tag, "_lat"}, 64'(cyc), 64'(vecs[i].lat));
            chk({tag, "_adds"}, 64'(nadd), 64'(vecs[i].p));
            chk({tag, "_shls"}, 64'(nshl), 64'(vecs[i].l));
            chk({tag, "_drive"}, 64'(bad), 64'd0);
            chk({tag, "_product"}, bus.product, vecs[i].prod);
            chk({tag, "_ovf"}, {63'd0, bus.ovf}, {63'd0, vecs[i].ovf});
            chk({tag, "_busy_in_done"}, {63'd0, bus.busy}, 64'd0);
            @(negedge clock);
            chk({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
            chk({tag, "_product_hold"}, bus.product, vecs[i].prod);
        end

        // Start while busy: second request is ignored, first result comes back.
        bus.start        = 1'b1;
        bus.multiplicand = 64'h11;
        bus.multiplier   = 64'h6;
        @(negedge clock);
        bus.multiplicand = 64'hAAAA;
        bus.multiplier   = 64'h1;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done(2, cyc, nadd, nshl, seq, bad);
        chk("busy_start_lat", 64'(cyc), 64'd6);
        chk("busy_start_product", bus.product, 64'h66);
        @(negedge clock);

        // Back-to-back: start held through DONE chains 3*5 into 7*7.
        bus.start        = 1'b1;
        bus.multiplicand = 64'd3;
        bus.multiplier   = 64'd5;
        @(negedge clock);
        bus.multiplicand = 64'd7;
        bus.multiplier   = 64'd7;
        wait_done(1, cyc, nadd, nshl, seq, bad);
        chk("b2b_first_lat", 64'(cyc), 64'd6);
        chk("b2b_fs_seq", {59'd0, seq[4:0]}, 64'b10010);
        chk("b2b_fs_count", 64'(nadd + nshl), 64'd5);
        chk("b2b_first_product", bus.product, 64'd15);
        @(negedge clock);
        bus.start = 1'b0;
        chk("b2b_no_gap_busy", {63'd0, bus.busy}, 64'd1);
        chk("b2b_no_gap_fs", {59'd0, bus.alu_FS}, {59'd0, FS_ADD});
        wait_done(1, cyc, nadd, nshl, seq, bad);
        chk("b2b_second_lat", 64'(cyc), 64'd7);
        chk("b2b_second_product", bus.product, 64'd49);
        @(negedge clock);

        // Reset in the middle of a long operation aborts it silently.
        bus.start        = 1'b1;
        bus.multiplicand = 64'hFF;
        bus.multiplier   = 64'hFF;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("mid_busy_before_rst", {63'd0, bus.busy}, 64'd1);
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("mid_rst_done", {63'd0, bus.done}, 64'd0);
        chk("mid_rst_product", bus.product, 64'd0);
        chk("mid_rst_ovf", {63'd0, bus.ovf}, 64'd0);
        chk("mid_rst_fs", {59'd0, bus.alu_FS}, 64'd0);
        reset_n = 1'b1;
        hits = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bus.done === 1'b1 || bus.busy === 1'b1) hits++;
        end
        chk("mid_rst_no_done", 64'(hits), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
